// File: rtl/sb_rmw_ctrl.sv
// sb_rmw_ctrl -- load/store unit front end with read-modify-write byte stores.
//
// Handles lw/lb/lbu/sw/sb against a word-wide memory that has combinational
// read data. A byte store reads the containing word, merges the new byte
// into its lane and writes the whole word back. Lanes are little-endian:
// lane k holds bits 8k+7:8k.
//
// Optional feature (macro SB_RMW_MISALIGN_TRAP_EN):
//   When defined, a word access with addr[1:0] != 0 skips memory entirely.
//   It goes straight to RESP with o_resp_err=1 and leaves o_resp_rdata as it was.
//   When undefined, word accesses ignore addr[1:0] and o_resp_err is tied to 0.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   i_req_valid         request present
//   o_req_ready         unit can accept a request (IDLE only)
//   i_req_we            1 = store, 0 = load
//   i_req_byte          1 = byte access, 0 = word access
//   i_req_unsigned      zero-extend (1) or sign-extend (0) on byte loads
//   i_req_addr          byte address
//   i_req_wdata         store data; byte stores use [7:0]
//   o_resp_valid        one-cycle completion pulse
//   o_resp_rdata        load result; held between loads
//   o_resp_err          misaligned-word error, qualified by o_resp_valid
//   o_mem_addr          word-aligned memory address (0 outside READ/WRITE)
//   o_mem_we            memory write enable
//   o_mem_wdata         memory write data (0 when o_mem_we is 0)
//   i_mem_rdata         combinational read data for o_mem_addr
module sb_rmw_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic              i_req_byte,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        r_state, w_state_nxt;
  logic              r_we, r_byte, r_uns;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;       // word captured in READ for the merge
  logic [31:0]       r_rdata;
  logic              w_accept;
  logic              w_trap;
  logic [7:0]        w_lane;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merged;

  assign w_accept = i_req_valid && (r_state == S_IDLE);

`ifdef SB_RMW_MISALIGN_TRAP_EN
  logic r_err;
  assign w_trap     = !i_req_byte && (i_req_addr[1:0] != 2'b00);
  assign o_resp_err = (r_state == S_RESP) && r_err;
`else
  assign w_trap     = 1'b0;
  assign o_resp_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_trap)                      w_state_nxt = S_RESP;
          else if (i_req_we && !i_req_byte) w_state_nxt = S_WRITE;
          else                             w_state_nxt = S_READ;
        end
      end
      S_READ:  w_state_nxt = r_we ? S_WRITE : S_RESP;
      S_WRITE: w_state_nxt = S_RESP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lane pick from the live read data; only meaningful in READ.
  always_comb begin
    w_lane = 8'h00;
    case (r_addr[1:0])
      2'd0: w_lane = i_mem_rdata[7:0];
      2'd1: w_lane = i_mem_rdata[15:8];
      2'd2: w_lane = i_mem_rdata[23:16];
      default: w_lane = i_mem_rdata[31:24];
    endcase
  end

  always_comb begin
    w_load_data = i_mem_rdata;
    if (r_byte)
      w_load_data = r_uns ? {24'h0, w_lane} : {{24{w_lane[7]}}, w_lane};
  end

  // Replace only the addressed lane of the captured word.
  always_comb begin
    w_merged = r_word;
    case (r_addr[1:0])
      2'd0: w_merged[7:0]   = r_wdata[7:0];
      2'd1: w_merged[15:8]  = r_wdata[7:0];
      2'd2: w_merged[23:16] = r_wdata[7:0];
      default: w_merged[31:24] = r_wdata[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_rdata <= '0;
`ifdef SB_RMW_MISALIGN_TRAP_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= i_req_we;
        r_byte  <= i_req_byte;
        r_uns   <= i_req_unsigned;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
`ifdef SB_RMW_MISALIGN_TRAP_EN
        r_err   <= w_trap;
`endif
      end
      // A load result is committed at the end of READ, so it is visible in
      // RESP; stores only keep the word for the merge and leave r_rdata alone.
      if (r_state == S_READ) begin
        if (r_we) r_word  <= i_mem_rdata;
        else      r_rdata <= w_load_data;
      end
    end
  end

  // All memory-facing outputs decode from state so reset drops them at once.
  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = r_rdata;
  assign o_mem_we     = (r_state == S_WRITE);
  assign o_mem_addr   = ((r_state == S_READ) || (r_state == S_WRITE)) ?
                        {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign o_mem_wdata  = (r_state != S_WRITE) ? 32'h0 :
                        (r_byte ? w_merged : r_wdata);

endmodule
